// File: rtl/pk_poci.sv
// pk_poci: POCI bus addresses plus LED scroller state type and 7-segment encoder.
package pk_poci;
   localparam logic [31:0] addr_hex  = 32'h0000_0010;
   localparam logic [31:0] addr_ledg = 32'h0000_0014;
   typedef enum logic [2:0] {
      IDLE, WAIT, HEX_SETUP, HEX_ACCESS, RD_SETUP, RD_ACCESS, LED_SETUP, LED_ACCESS
   } led_scroll_state_t;
   // Segment bit0 = a ... bit6 = g, active-high.
   function automatic logic [6:0] seg7_encode(input logic [3:0] d);
      case (d)
         4'h0: return 7'h3F;
         4'h1: return 7'h06;
         4'h2: return 7'h5B;
         4'h3: return 7'h4F;
         4'h4: return 7'h66;
         4'h5: return 7'h6D;
         4'h6: return 7'h7D;
         4'h7: return 7'h07;
         4'h8: return 7'h7F;
         4'h9: return 7'h6F;
         4'hA: return 7'h77;
         4'hB: return 7'h7C;
         4'hC: return 7'h39;
         4'hD: return 7'h5E;
         4'hE: return 7'h79;
         default: return 7'h71;
      endcase
   endfunction
endpackage

// File: rtl/led_scroll_word.sv
// led_scroll_word: builds the 4-digit HEX register word for scroll position p.
module led_scroll_word
   import pk_poci::*;
(
   input  logic [31:0] msg,
   input  logic [2:0]  p,
   output logic [31:0] word
);
   for (genvar k = 0; k < 4; k++) begin : g_dig
      logic [2:0] idx;
      assign idx = p + 3'(k);
      assign word[8*k +: 8] = {1'b0, seg7_encode(msg[{idx, 2'b00} +: 4])};
   end
endmodule

// File: rtl/poci_led_scroller.sv
// poci_led_scroller: POCI master scrolling an 8-nibble message over the 7-segment digits.
module poci_led_scroller
   import pk_poci::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        run,
   input  logic [31:0] msg,
   output logic [31:0] paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr,
   output logic [2:0]  pos,
   output logic        busy,
   output logic        err
);
   localparam int CW = $clog2(TICK_DIV);
   if (TICK_DIV < 16) begin : g_tick_chk
      $error("TICK_DIV must be >= 16");
   end
   led_scroll_state_t st;
   logic [CW-1:0] cnt;
   logic tick, start;
   logic [2:0] wp;
   logic [31:0] word;
   assign wp = (st == IDLE) ? 3'd0 : pos;
   assign start = run && (st == IDLE || (st == WAIT && tick));
   led_scroll_word u_word (.msg(msg), .p(wp), .word(word));
   // tick marks the cycle after the terminal count; pos is already advanced there.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         st      <= IDLE;
         cnt     <= '0;
         tick    <= 1'b0;
         pos     <= 3'd0;
         busy    <= 1'b0;
         err     <= 1'b0;
         paddr   <= '0;
         pwdata  <= '0;
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
      end else if (start) begin
         st     <= HEX_SETUP;
         tick   <= 1'b0;
         cnt    <= '0;
         pos    <= wp;
         busy   <= 1'b1;
         psel   <= 1'b1;
         pwrite <= 1'b1;
         paddr  <= addr_hex;
         pwdata <= word;
      end else begin
         case (st)
            IDLE: if (!run) err <= 1'b0;
            WAIT:
               if (!run) begin
                  st   <= IDLE;
                  cnt  <= '0;
                  tick <= 1'b0;
               end else if (cnt == CW'(TICK_DIV - 1)) begin
                  tick <= 1'b1;
                  cnt  <= '0;
                  pos  <= pos + 3'd1;
               end else cnt <= cnt + 1'b1;
            HEX_SETUP, RD_SETUP, LED_SETUP: begin
               penable <= 1'b1;
               st      <= led_scroll_state_t'(st + 3'd1);
            end
            HEX_ACCESS:
               if (pready) begin
                  err     <= err | pslverr;
                  penable <= 1'b0;
                  pwrite  <= 1'b0;
                  st      <= RD_SETUP;
               end
            // pwdata still holds the HEX word during the readback.
            RD_ACCESS:
               if (pready) begin
                  err     <= err | pslverr | (prdata != pwdata);
                  penable <= 1'b0;
                  pwrite  <= 1'b1;
                  paddr   <= addr_ledg;
                  pwdata  <= {24'd0, 8'd1 << pos};
                  st      <= LED_SETUP;
               end
            LED_ACCESS:
               if (pready) begin
                  err     <= err | pslverr;
                  psel    <= 1'b0;
                  penable <= 1'b0;
                  pwrite  <= 1'b0;
                  busy    <= 1'b0;
                  cnt     <= '0;
                  st      <= run ? WAIT : IDLE;
               end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_poci_led_scroller.sv
// tb_poci_led_scroller: randomized bench with a transfer-level reference model of the scroller.
module tb_poci_led_scroller;
   import pk_poci::*;
   localparam int TD = 16;
   logic pclk = 1'b0, presetn = 1'b1, run = 1'b0;
   logic [31:0] msg = '0, paddr, pwdata, prdata;
   logic pready, pslverr, psel, penable, pwrite, busy, err;
   logic [2:0] pos;
   always #5 pclk = ~pclk;
   poci_led_scroller #(.TICK_DIV(TD)) dut (
      .pclk(pclk), .presetn(presetn), .run(run), .msg(msg), .paddr(paddr), .psel(psel),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .pos(pos), .busy(busy), .err(err)
   );
   int checks = 0, errors = 0;
   typedef struct packed {
      logic [31:0] a;
      logic        w;
      logic [31:0] wd;
      logic [31:0] rd;
      logic [2:0]  ps;
   } xfer_t;
   xfer_t xq[$];
   logic [31:0] mq[$];
   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [1:0] ws = '0;
   int stall_n = 0, unstable = 0, cyc = 0, bcnt = 0, blen = 0, last_start = 0, prev_start = 0;
   logic [31:0] stall_addr = '0, mem_hex = '0, msg_q = '0, s_addr = '0, s_data = '0;
   logic stall_wr = 1'b0, s_wr = 1'b0, rnd_ws = 1'b0, rnd_msg = 1'b0, bad_rd = 1'b0, slverr_led = 1'b0;
   assign pready  = (ws == 2'd0);
   assign prdata  = bad_rd ? 32'd0 : mem_hex;
   assign pslverr = slverr_led && paddr == addr_ledg;
   // Slave responder and transfer monitor.
   always @(posedge pclk) begin
      cyc   <= cyc + 1;
      msg_q <= msg;
      if (busy) bcnt <= bcnt + 1;
      else if (bcnt != 0) begin
         blen <= bcnt;
         bcnt <= 0;
      end
      if (psel && !penable) begin
         s_addr <= paddr;
         s_data <= pwdata;
         s_wr   <= pwrite;
         ws <= (stall_n != 0 && paddr == stall_addr && pwrite == stall_wr) ? 2'(stall_n) :
               rnd_ws ? 2'($urandom_range(0, 3)) : 2'd0;
         if (pwrite && paddr == addr_hex) begin
            mq.push_back(msg_q);
            prev_start <= last_start;
            last_start <= cyc;
         end
      end else if (psel && penable) begin
         if (paddr !== s_addr || pwdata !== s_data || pwrite !== s_wr) unstable <= unstable + 1;
         if (ws != 2'd0) ws <= ws - 2'd1;
         else begin
            xq.push_back(xfer_t'{paddr, pwrite, pwdata, prdata, pos});
            if (pwrite && paddr == addr_hex) mem_hex <= pwdata;
         end
      end
   end
   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] model_word(input logic [31:0] m, input int p);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = {1'b0, seg_tab[(m >> (4 * ((p + k) % 8))) & 32'hF]};
      return w;
   endfunction
   task automatic expect_step(input int p, output logic [31:0] hw);
      logic [31:0] w;
      xfer_t t;
      int n = 0;
      hw = '0;
      while (xq.size() < 3 && n < 400) begin
         @(negedge pclk);
         n++;
         if (rnd_msg && $urandom_range(0, 3) == 0) msg = $urandom;
      end
      if (xq.size() < 3 || mq.size() == 0) begin
         chk("step_timeout", 96'(xq.size()), 96'd3);
         return;
      end
      @(negedge pclk);
      w = model_word(mq.pop_front(), p);
      t = xq.pop_front();
      chk("hex_wr", {t.a, t.w, t.wd}, {addr_hex, 1'b1, w});
      hw = t.wd;
      t = xq.pop_front();
      chk("hex_rd", {t.a, t.w}, {addr_hex, 1'b0});
      if (!bad_rd) chk("rd_data", t.rd, w);
      t = xq.pop_front();
      chk("ledg_wr", {t.a, t.w, t.wd, t.ps}, {addr_ledg, 1'b1, 24'd0, 8'd1 << p, 3'(p)});
   endtask
   initial begin
      int p, n;
      logic [31:0] hw;
      #1 presetn = 1'b0;
      repeat (3) @(negedge pclk);
      chk("rst_ctl", {psel, penable, pwrite, busy, err, pos}, '0);
      chk("rst_addr", paddr, '0);
      chk("rst_wdata", pwdata, '0);
      presetn = 1'b1;
      @(negedge pclk);
      msg = 32'h7654_3210;
      run = 1'b1;
      @(negedge pclk);
      chk("first_setup", {psel, penable, pwrite, busy, paddr}, {4'b1011, addr_hex});
      p = 0;
      for (int s = 0; s < 9; s++) begin
         expect_step(p, hw);
         if (s == 0) begin
            chk("hex0", hw, 32'h4F5B063F);
            chk("busy_len", 96'(blen), 96'd6);
         end
         if (s == 1) begin
            chk("hex1", hw, 32'h664F5B06);
            chk("period", 96'(last_start - prev_start), 96'(TD + 7));
         end
         if (s == 8) begin
            chk("wrap_hex", hw, 32'h4F5B063F);
            chk("wrap_pos", pos, 3'd0);
         end
         p = (p + 1) % 8;
      end
      rnd_ws = 1'b1;
      rnd_msg = 1'b1;
      for (int s = 0; s < 12; s++) begin
         expect_step(p, hw);
         p = (p + 1) % 8;
      end
      rnd_ws = 1'b0;
      rnd_msg = 1'b0;
      stall_addr = addr_hex;
      stall_wr = 1'b1;
      stall_n = 3;
      expect_step(p, hw);
      chk("stall_busy_len", 96'(blen), 96'd9);
      stall_n = 0;
      p = (p + 1) % 8;
      chk("err_clean", err, 1'b0);
      bad_rd = 1'b1;
      slverr_led = 1'b1;
      expect_step(p, hw);
      bad_rd = 1'b0;
      slverr_led = 1'b0;
      chk("err_set", err, 1'b1);
      for (int s = 0; s < 2; s++) begin
         p = (p + 1) % 8;
         expect_step(p, hw);
         chk("err_sticky", err, 1'b1);
      end
      run = 1'b0;
      repeat (3) @(negedge pclk);
      chk("idle_err_clr", err, 1'b0);
      chk("idle_bus", {busy, psel}, 2'b00);
      chk("idle_pos", pos, 3'(p));
      run = 1'b1;
      n = 0;
      while (!(psel && penable && !pwrite) && n < 400) begin
         @(negedge pclk);
         n++;
      end
      chk("rd_reach", {psel, penable, pwrite}, 3'b110);
      run = 1'b0;
      expect_step(0, hw);
      chk("rd_stop", {busy, psel}, 2'b00);
      repeat (30) @(negedge pclk);
      chk("no_more_xfers", 96'(xq.size() + mq.size()), 96'd0);
      chk("stable", 96'(unstable), 96'd0);
      run = 1'b1;
      stall_addr = addr_ledg;
      stall_wr = 1'b1;
      stall_n = 3;
      n = 0;
      while (!(psel && penable && paddr == addr_ledg) && n < 400) begin
         @(negedge pclk);
         n++;
      end
      chk("led_reach", {psel, penable, paddr}, {2'b11, addr_ledg});
      #2 presetn = 1'b0;
      #1;
      chk("arst_ctl", {psel, penable, pwrite, busy, err, pos}, '0);
      chk("arst_addr", paddr, '0);
      chk("arst_wdata", pwdata, '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/poci_led_scroller.md
# poci_led_scroller

POCI master that sequences the board LED/7-segment driver on the peripheral bus. It scrolls an 8-digit hex message across the four 7-segment digits, one position per prescaler tick. Each step writes the HEX register, reads it back to check it, then writes the LEDG register with a one-hot position marker. It sits between the system control logic and the LED driver's POCI slave port, and is the only master that addresses that slave.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per scroll step; must be ≥ 16 (elaboration check).
- `pclk` in 1: bus clock; the only clock.
- `presetn` in 1: reset; one clock; reset is asynchronous and active-low.
- `run` in 1: level; 1 = scrolling enabled.
- `msg` in 32: 8 hex nibbles; nibble i = `msg[4i+3:4i]`.
- `paddr` out 32: POCI address (`addr_hex` or `addr_ledg` from `pk_poci`).
- `psel`, `penable`, `pwrite` out 1 each: POCI control.
- `pwdata` out 32: write data.
- `prdata` in 32: read data.
- `pready` in 1: slave ready.
- `pslverr` in 1: slave error.
- `pos` out 3: current scroll position p.
- `busy` out 1: 1 while a step sequence is in flight.
- `err` out 1: sticky; set on readback mismatch or `pslverr`.

## Operation
- States: IDLE, WAIT, HEX_SETUP, HEX_ACCESS, RD_SETUP, RD_ACCESS, LED_SETUP, LED_ACCESS.
- IDLE:
  - With `run`=1, go to HEX_SETUP with p=0.
  - `err` is cleared while in IDLE with `run`=0.
- Step data:
  - `msg` is latched at HEX_SETUP entry, so a mid-step `msg` change has no effect.
  - Digit k (k=0 rightmost) shows nibble (p+k) mod 8.
  - Byte k of `pwdata` = {1'b0, seg(nibble)}; seg bit0 = segment a … bit6 = segment g; segments are active-high.
  - seg values: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71.
- Transfer protocol (APB-style):
  - SETUP: `psel`=1, `penable`=0, for 1 cycle.
  - ACCESS: `psel`=1, `penable`=1, held until `pready`=1.
  - `paddr`, `pwrite` and `pwdata` are stable across SETUP and ACCESS.
- Step sequence:
  - Write `addr_hex` with the encoded word.
  - Read `addr_hex`; at the `pready` cycle, compare `prdata` with the written word; a mismatch sets `err`.
  - Write `addr_ledg` with `8'b1 << p`.
  - Then go to WAIT.
- `pslverr`=1 in any ACCESS completion sets `err`; the sequence continues regardless.
- WAIT:
  - Prescaler counts 0…TICK_DIV−1.
  - At the terminal count: p ← (p+1) mod 8 (wraps 7→0), then go to HEX_SETUP.
- `run`=0:
  - In WAIT: go to IDLE immediately, prescaler cleared.
  - During a step: the current transfer and remaining step transfers complete, then go to IDLE.
  - `pos` holds its last value in IDLE. The next `run` rise restarts at p=0.
- Prescaler: counts only in WAIT; cleared on entry to WAIT and in IDLE.

## Timing
- Reset values: `psel`=`penable`=`pwrite`=0, `paddr`=0, `pwdata`=0, `pos`=0, `busy`=0, `err`=0, state IDLE, prescaler 0.
- Reset assertion mid-transfer: `psel`/`penable` drop asynchronously. No completion is required.
- First HEX_SETUP is in the cycle after `run` is sampled 1 in IDLE.
- Each transfer takes 2 cycles plus pready wait states; a step takes at least 6 cycles.
- `busy`:
  - Rises with HEX_SETUP.
  - Falls in the cycle after LED_ACCESS completes.
- Step period in steady state: TICK_DIV + 1 + 6 + wait states. The prescaler does not run during a step, so ticks are never dropped or queued.
- Unbounded `pready`=0 stalls the FSM in ACCESS. There is no timeout.

## Structure
- Add to `pk_poci`:
  - the state enum `led_scroll_state_t`;
  - the function `seg7_encode(logic [3:0]) → logic [6:0]`.
- Sub-module `led_scroll_word`: combinational, takes (msg, p) and returns the 32-bit HEX word using `seg7_encode`.
- The FSM, prescaler, `pos` and `err` live in the top module.

## Test plan
- Reset, then `run`=1, `msg`=32'h7654_3210, `pready`=1, TICK_DIV=16:
  - first transfers: write `addr_hex` 32'h4F5B063F; read it back; write `addr_ledg` 8'h01.
  - `busy` is high for 6 cycles.
- Continue the same run:
  - After 16 WAIT cycles: write 32'h664F5B06, then `addr_ledg` 8'h02.
  - After 8 steps: `pos` wraps to 0 and the data is 32'h4F5B063F again.
- Hold `pready`=0 for 3 cycles in HEX_ACCESS:
  - `psel`, `penable`, `paddr` and `pwdata` are stable throughout;
  - the step completes 3 cycles late.
- Readback `prdata`=32'h0 (mismatch), then `pslverr`=1 on the LEDG write:
  - `err`=1 and stays set through later steps;
  - after `run`=0 and return to IDLE, `err`=0.
- `run`=0 during RD_ACCESS: the read and the LEDG write complete, then IDLE with `busy`=0 and `psel`=0.
- `presetn` low during LED_ACCESS: all outputs take reset values without waiting for a clock edge.
